// File: rtl/asmd_run_sequencer_if.sv
// rtl/asmd_run_sequencer_if.sv - request/status bundle between the host-side run sequencer and the ASMD pair
interface asmd_run_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             req_in;
  logic             F_in;
  logic [3:0]       A_in;
  logic             E_in;
  logic             start;
  logic             busy;
  logic             result_valid;
  logic [3:0]       result_A;
  logic             result_E;
  logic [CNT_W-1:0] run_count;
  logic             timeout_err;

  modport master (
    output req_in, F_in, A_in, E_in,
    input  start, busy, result_valid, result_A, result_E, run_count, timeout_err
  );

  modport slave (
    input  req_in, F_in, A_in, E_in,
    output start, busy, result_valid, result_A, result_E, run_count, timeout_err
  );
endinterface

// File: rtl/asmd_run_sequencer.sv
// rtl/asmd_run_sequencer.sv - debounced run request, start pulse and result capture for the ASMD pair
// Optional run watchdog enabled by ASMD_RUN_SEQ_TIMEOUT_EN.
module asmd_run_sequencer #(
  parameter int DEB_CYCLES     = 16,
`ifdef ASMD_RUN_SEQ_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 64,
`endif
  parameter int CNT_W          = 8
) (
  input logic                 clk,
  input logic                 rstb,
  asmd_run_sequencer_if.slave bus
);

  localparam int               DEB_W   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FIRE      = 2'd1,
    WAIT_CLR  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             req_meta;
  logic             req_sync;
  logic             req_deb;
  logic             req_deb_d;
  logic [DEB_W-1:0] deb_cnt;
  logic             req_rise;
  logic             start_c;
  logic             done_c;
  logic             result_valid_q;
  logic [3:0]       result_a_q;
  logic             result_e_q;
  logic [CNT_W-1:0] run_count_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      req_meta <= 1'b0;
      req_sync <= 1'b0;
    end else begin
      req_meta <= bus.req_in;
      req_sync <= req_meta;
    end
  end

  // req_deb only moves after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      deb_cnt   <= '0;
      req_deb   <= 1'b0;
      req_deb_d <= 1'b0;
    end else begin
      req_deb_d <= req_deb;
      if (req_sync == req_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_MAX) begin
        req_deb <= ~req_deb;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign req_rise = req_deb & ~req_deb_d;
  assign done_c   = (state_q == WAIT_DONE) && bus.F_in;

`ifdef ASMD_RUN_SEQ_TIMEOUT_EN
  localparam int              TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            waiting;
  logic            expire_c;
  logic            timeout_err_q;

  assign waiting  = (state_q == WAIT_CLR) || (state_q == WAIT_DONE);
  // a completion landing on the expiry cycle still counts as a good run
  assign expire_c = waiting && !done_c && (to_cnt == TO_MAX);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      to_cnt        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == FIRE) begin
        to_cnt <= '0;
      end else if (waiting) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (expire_c) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_rise) begin
          state_d = FIRE;
        end
      end
      FIRE: begin
        start_c = 1'b1;
        state_d = WAIT_CLR;
      end
      // F may still hold the previous run's value until the ASMD clears it
      WAIT_CLR: begin
        if (!bus.F_in) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.F_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef ASMD_RUN_SEQ_TIMEOUT_EN
    if (expire_c) begin
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      result_valid_q <= 1'b0;
      result_a_q     <= 4'd0;
      result_e_q     <= 1'b0;
      run_count_q    <= '0;
    end else begin
      result_valid_q <= done_c;
      if (done_c) begin
        result_a_q  <= bus.A_in;
        result_e_q  <= bus.E_in;
        run_count_q <= run_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.start        = start_c;
  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = result_valid_q;
  assign bus.result_A     = result_a_q;
  assign bus.result_E     = result_e_q;
  assign bus.run_count    = run_count_q;

endmodule

// File: tb/tb_asmd_run_sequencer.sv
// tb/tb_asmd_run_sequencer.sv - randomized self-checking bench for asmd_run_sequencer
// Two instances share stimulus: CNT_W=8 and CNT_W=2 (counter wrap).
module tb_asmd_run_sequencer;

  localparam int DEB = 16;
  localparam int LAT = 2 + DEB + 1;
  localparam int TO  = 64;

  logic       clk  = 1'b0;
  logic       rstb = 1'b0;
  logic       req  = 1'b0;
  logic       f    = 1'b0;
  logic       e    = 1'b0;
  logic [3:0] a    = 4'd0;

  int total = 0;
  int bad   = 0;
  int runs  = 0;
  int start_cnt    = 0;
  int rv_cnt       = 0;
  int double_start = 0;
  logic prev_start = 1'b0;

  always #5 clk = ~clk;

  asmd_run_sequencer_if #(.CNT_W(8)) bus8 ();
  asmd_run_sequencer_if #(.CNT_W(2)) bus2 ();

  assign bus8.req_in = req;
  assign bus8.F_in   = f;
  assign bus8.A_in   = a;
  assign bus8.E_in   = e;
  assign bus2.req_in = req;
  assign bus2.F_in   = f;
  assign bus2.A_in   = a;
  assign bus2.E_in   = e;

  asmd_run_sequencer #(.DEB_CYCLES(DEB), .CNT_W(8)) dut8 (.clk(clk), .rstb(rstb), .bus(bus8.slave));
  asmd_run_sequencer #(.DEB_CYCLES(DEB), .CNT_W(2)) dut2 (.clk(clk), .rstb(rstb), .bus(bus2.slave));

  always @(negedge clk) begin
    if (bus8.start === 1'b1) start_cnt++;
    if (bus8.start === 1'b1 && prev_start === 1'b1) double_start++;
    prev_start = bus8.start;
    if (bus8.result_valid === 1'b1) rv_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic do_reset;
    rstb = 1'b0; req = 1'b0; f = 1'b0; a = 4'd0; e = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    runs = 0;
    @(negedge clk);
  endtask

  task automatic release_req;
    req = 1'b0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic wait_start(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 4 * LAT) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus8.start === 1'b1) seen = 1'b1;
    end
    if (!seen) n = -1;
  endtask

  // Called in the FIRE cycle (or later while waiting); ASMD returns av/ev with F.
  task automatic finish_run(input int stale, input int w, input logic [3:0] av, input logic ev, input string tag);
    f = 1'b1; a = 4'($urandom); e = 1'($urandom);
    repeat (stale) @(negedge clk);
    f = 1'b0;
    repeat (w) @(negedge clk);
    total++;
    if (bus8.busy !== 1'b1) begin bad++; $display("FAIL %s_busy_wait got=%0b exp=1", tag, bus8.busy); end
    a = av; e = ev; f = 1'b1;
    @(negedge clk);
    runs++;
    total++;
    if (bus8.result_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%0b exp=1", tag, bus8.result_valid); end
    total++;
    if (bus8.result_A !== av) begin bad++; $display("FAIL %s_result_A got=%0d exp=%0d", tag, bus8.result_A, av); end
    total++;
    if (bus8.result_E !== ev) begin bad++; $display("FAIL %s_result_E got=%0b exp=%0b", tag, bus8.result_E, ev); end
    total++;
    if (bus8.busy !== 1'b0) begin bad++; $display("FAIL %s_busy_done got=%0b exp=0", tag, bus8.busy); end
    total++;
    if (bus8.run_count !== runs[7:0]) begin bad++; $display("FAIL %s_count8 got=%0d exp=%0d", tag, bus8.run_count, runs[7:0]); end
    total++;
    if (bus2.run_count !== runs[1:0]) begin bad++; $display("FAIL %s_count2 got=%0d exp=%0d", tag, bus2.run_count, runs[1:0]); end
    a = ~av; e = ~ev;
    @(negedge clk);
    total++;
    if (bus8.result_valid !== 1'b0) begin bad++; $display("FAIL %s_valid_pulse got=%0b exp=0", tag, bus8.result_valid); end
    total++;
    if (bus8.result_A !== av) begin bad++; $display("FAIL %s_hold_A got=%0d exp=%0d", tag, bus8.result_A, av); end
  endtask

  task automatic test_reset;
    int s0;
    rstb = 1'b0;
    runs = 0;
    for (int i = 0; i < 6; i++) begin
      req = 1'($urandom); f = 1'($urandom); a = 4'($urandom); e = 1'($urandom);
      @(negedge clk);
    end
    total++;
    if (bus8.start !== 1'b0) begin bad++; $display("FAIL reset_start got=%0b exp=0", bus8.start); end
    total++;
    if (bus8.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus8.busy); end
    total++;
    if (bus8.result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus8.result_valid); end
    total++;
    if (bus8.result_A !== 4'd0) begin bad++; $display("FAIL reset_result_A got=%0d exp=0", bus8.result_A); end
    total++;
    if (bus8.result_E !== 1'b0) begin bad++; $display("FAIL reset_result_E got=%0b exp=0", bus8.result_E); end
    total++;
    if (bus8.run_count !== 8'd0) begin bad++; $display("FAIL reset_count8 got=%0d exp=0", bus8.run_count); end
    total++;
    if (bus2.run_count !== 2'd0) begin bad++; $display("FAIL reset_count2 got=%0d exp=0", bus2.run_count); end
    total++;
    if (bus8.timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%0b exp=0", bus8.timeout_err); end
    req = 1'b0;
    rstb = 1'b1;
    s0 = start_cnt;
    repeat (40) begin
      f = 1'($urandom); a = 4'($urandom); e = 1'($urandom);
      @(negedge clk);
    end
    #1;
    total++;
    if (start_cnt !== s0) begin bad++; $display("FAIL reset_idle_start got=%0d exp=%0d", start_cnt, s0); end
  endtask

  task automatic test_random_bounce;
    int s0;
    s0 = start_cnt;
    for (int b = 0; b < 10; b++) begin
      req = ~req;
      repeat ($urandom_range(1, DEB - 2)) @(negedge clk);
    end
    release_req();
    #1;
    total++;
    if (start_cnt !== s0) begin bad++; $display("FAIL random_bounce_starts got=%0d exp=%0d", start_cnt - s0, 0); end
  endtask

  task automatic test_bounce;
    int s0;
    int n;
    s0 = start_cnt;
    for (int i = 0; i < 39; i++) begin
      req = ((i / 3) % 2) == 1;
      @(negedge clk);
    end
    req = 1'b1;
    wait_start(n);
    total++;
    if (n !== LAT) begin bad++; $display("FAIL bounce_latency got=%0d exp=%0d", n, LAT); end
    finish_run($urandom_range(0, 3), $urandom_range(2, 6), 4'($urandom), 1'($urandom), "bounce_run");
    #1;
    total++;
    if (start_cnt - s0 !== 1) begin bad++; $display("FAIL bounce_start_count got=%0d exp=1", start_cnt - s0); end
    release_req();
  endtask

  task automatic test_full_run;
    int n;
    int steps;
    logic [3:0] am;
    logic em, fm;
    do_reset();
    req = 1'b1;
    wait_start(n);
    total++;
    if (n !== LAT) begin bad++; $display("FAIL full_latency got=%0d exp=%0d", n, LAT); end
    am = 4'd0; em = 1'b0; fm = 1'b0;
    a = am; e = em; f = fm;
    steps = 0;
    while (!fm && steps < 32) begin
      @(negedge clk);
      fm = am[3] & am[2];
      em = am[2];
      am = am + 4'd1;
      a = am; e = em; f = fm;
      steps++;
    end
    @(negedge clk);
    runs++;
    total++;
    if (bus8.result_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%0b exp=1", bus8.result_valid); end
    total++;
    if (bus8.result_A !== 4'd13) begin bad++; $display("FAIL full_result_A got=%0d exp=13", bus8.result_A); end
    total++;
    if (bus8.result_E !== 1'b1) begin bad++; $display("FAIL full_result_E got=%0b exp=1", bus8.result_E); end
    total++;
    if (bus8.run_count !== 8'd1) begin bad++; $display("FAIL full_count got=%0d exp=1", bus8.run_count); end
    total++;
    if (bus8.busy !== 1'b0) begin bad++; $display("FAIL full_busy got=%0b exp=0", bus8.busy); end
    release_req();
  endtask

  task automatic test_hold_off;
    int n;
    int s0;
    do_reset();
    req = 1'b1;
    wait_start(n);
    total++;
    if (n !== LAT) begin bad++; $display("FAIL hold_latency1 got=%0d exp=%0d", n, LAT); end
    #1;
    s0 = start_cnt;
    f = 1'b1; @(negedge clk);
    f = 1'b0; repeat (2) @(negedge clk);
    req = 1'b0; repeat (LAT + 2) @(negedge clk);
    req = 1'b1; repeat (LAT + 4) @(negedge clk);
    #1;
    total++;
    if (start_cnt !== s0) begin bad++; $display("FAIL hold_busy_press got=%0d exp=%0d", start_cnt, s0); end
    finish_run(0, 2, 4'($urandom), 1'($urandom), "hold_run1");
    repeat (30) @(negedge clk);
    #1;
    total++;
    if (start_cnt !== s0) begin bad++; $display("FAIL hold_no_reedge got=%0d exp=%0d", start_cnt, s0); end
    release_req();
    req = 1'b1;
    wait_start(n);
    total++;
    if (n !== LAT) begin bad++; $display("FAIL hold_latency2 got=%0d exp=%0d", n, LAT); end
    finish_run($urandom_range(0, 3), $urandom_range(2, 6), 4'($urandom), 1'($urandom), "hold_run2");
    total++;
    if (bus8.run_count !== 8'd2) begin bad++; $display("FAIL hold_count got=%0d exp=2", bus8.run_count); end
    release_req();
  endtask

  task automatic test_wrap;
    int n;
    int exp2 [5] = '{1, 2, 3, 0, 1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req = 1'b1;
      wait_start(n);
      total++;
      if (n !== LAT) begin bad++; $display("FAIL wrap_latency%0d got=%0d exp=%0d", k, n, LAT); end
      finish_run($urandom_range(0, 3), $urandom_range(2, 6), 4'($urandom), 1'($urandom), "wrap_run");
      total++;
      if (int'(bus2.run_count) !== exp2[k]) begin bad++; $display("FAIL wrap_seq%0d got=%0d exp=%0d", k, bus2.run_count, exp2[k]); end
      release_req();
    end
  endtask

  task automatic test_timeout;
    int n;
    int r0;
    do_reset();
    req = 1'b1;
    wait_start(n);
    #1;
    r0 = rv_cnt;
    f = 1'b1;
`ifdef ASMD_RUN_SEQ_TIMEOUT_EN
    n = 0;
    while (n < 4 * TO) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus8.busy !== 1'b1) break;
    end
    total++;
    if (n !== TO + 1) begin bad++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TO + 1); end
    total++;
    if (bus8.timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%0b exp=1", bus8.timeout_err); end
    total++;
    if (bus8.run_count !== runs[7:0]) begin bad++; $display("FAIL timeout_count got=%0d exp=%0d", bus8.run_count, runs[7:0]); end
    #1;
    total++;
    if (rv_cnt !== r0) begin bad++; $display("FAIL timeout_no_valid got=%0d exp=%0d", rv_cnt, r0); end
    req = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (bus8.timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%0b exp=1", bus8.timeout_err); end
    rstb = 1'b0;
    @(negedge clk);
    total++;
    if (bus8.timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%0b exp=0", bus8.timeout_err); end
    rstb = 1'b1;
    runs = 0;
    @(negedge clk);
`else
    repeat (TO + 20) @(negedge clk);
    total++;
    if (bus8.busy !== 1'b1) begin bad++; $display("FAIL nowdog_busy got=%0b exp=1", bus8.busy); end
    total++;
    if (bus8.timeout_err !== 1'b0) begin bad++; $display("FAIL nowdog_err got=%0b exp=0", bus8.timeout_err); end
    #1;
    total++;
    if (rv_cnt !== r0) begin bad++; $display("FAIL nowdog_no_valid got=%0d exp=%0d", rv_cnt, r0); end
    finish_run(0, 2, 4'($urandom), 1'($urandom), "nowdog_run");
    release_req();
`endif
  endtask

  task automatic test_reset_mid_run;
    int n;
    int r0;
    do_reset();
    req = 1'b1;
    wait_start(n);
    f = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus8.busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%0b exp=1", bus8.busy); end
    #2;
    r0 = rv_cnt;
    rstb = 1'b0;
    runs = 0;
    #1;
    total++;
    if (bus8.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b exp=0", bus8.busy); end
    total++;
    if (bus8.result_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b exp=0", bus8.result_valid); end
    req = 1'b0; f = 1'b1; a = 4'($urandom_range(1, 15)); e = 1'b1;
    @(negedge clk);
    rstb = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (rv_cnt !== r0) begin bad++; $display("FAIL midrst_no_valid got=%0d exp=%0d", rv_cnt, r0); end
    total++;
    if (bus8.result_A !== 4'd0) begin bad++; $display("FAIL midrst_result_A got=%0d exp=0", bus8.result_A); end
    total++;
    if (bus8.run_count !== runs[7:0]) begin bad++; $display("FAIL midrst_count got=%0d exp=%0d", bus8.run_count, runs[7:0]); end
    total++;
    if (bus8.busy !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%0b exp=0", bus8.busy); end
  endtask

  initial begin
    test_reset();
    test_random_bounce();
    test_bounce();
    test_full_run();
    test_hold_off();
    test_wrap();
    test_timeout();
    test_reset_mid_run();
    total++;
    if (double_start !== 0) begin bad++; $display("FAIL start_back_to_back got=%0d exp=0", double_start); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
